// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the control FSM and mult_div_unit.
// master drives the request side; slave is the multiply/divide unit.
interface mult_div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, done, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/mult_div_unit.sv
// Sequential multiply/divide unit producing Hi/Lo, one iteration per cycle.
// Optional macro MULTDIV_UNSIGNED_EN enables multu/divu selection via op[1].
module mult_div_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = WIDTH
) (
  input  logic            clk,
  input  logic            reset_n,
  mult_div_unit_if.slave  bus
);

  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int unsigned AW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [AW-1:0]    acc, acc_step, prod_fix;
  logic [WIDTH-1:0] opnd;
  logic             is_div, neg_q, neg_r;

  logic             sgn_op, rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic             accept, is_dz, load_res;
  logic [WIDTH:0]   add_sum, shifted, diff;
  logic [WIDTH-1:0] q_fix, r_fix, hi_fix, lo_fix;

  logic             busy_q, done_q, dz_q;
  logic             busy_nxt, done_nxt, dz_nxt;
  logic [WIDTH-1:0] hi_q, lo_q;

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;
  assign bus.hi_out   = hi_q;
  assign bus.lo_out   = lo_q;

`ifdef MULTDIV_UNSIGNED_EN
  assign sgn_op = ~bus.op[1];
`else
  logic unused_op1;
  assign sgn_op     = 1'b1;
  assign unused_op1 = bus.op[1];
`endif

  // Operand decode: magnitudes and signs of the incoming request
  always_comb begin
    rs_neg = sgn_op & bus.rs_val[WIDTH-1];
    rt_neg = sgn_op & bus.rt_val[WIDTH-1];
    rs_mag = rs_neg ? -bus.rs_val : bus.rs_val;
    rt_mag = rt_neg ? -bus.rt_val : bus.rt_val;
    accept = (state == IDLE) & bus.start;
    is_dz  = bus.op[0] & (bus.rt_val == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = is_dz ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs are computed from the state being entered
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    dz_nxt   = 1'b0;
    load_res = 1'b0;
    busy_nxt = (state_nxt == CALC) || (state_nxt == FIX);
    done_nxt = (state_nxt == DONE);
    dz_nxt   = (state == IDLE) && (state_nxt == DONE);
    load_res = (state == FIX);
  end

  // One shift-add (mult) or restoring (div) step; acc = {rem, quot} for div
  always_comb begin
    add_sum  = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    shifted  = {acc[AW-1:WIDTH], acc[WIDTH-1]};
    diff     = shifted - {1'b0, opnd};
    acc_step = {add_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (diff[WIDTH]) acc_step = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else             acc_step = {diff[WIDTH-1:0],    acc[WIDTH-2:0], 1'b1};
    end
  end

  // Sign correction; remainder follows the dividend (truncating division)
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix    = neg_r ? -acc[AW-1:WIDTH] : acc[AW-1:WIDTH];
    hi_fix   = is_div ? r_fix : prod_fix[AW-1:WIDTH];
    lo_fix   = is_div ? q_fix : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      cnt    <= '0;
    end else begin
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      dz_q   <= dz_nxt;
      if (load_res) begin
        hi_q <= hi_fix;
        lo_q <= lo_fix;
      end
      if (accept)                           cnt <= CW'(ITER - 1);
      else if (state == CALC && cnt != '0)  cnt <= cnt - CW'(1);
    end
  end

  // Operand capture at start, then one iteration per CALC cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else if (accept) begin
      is_div <= bus.op[0];
      neg_q  <= rs_neg ^ rt_neg;
      neg_r  <= rs_neg;
      opnd   <= bus.op[0] ? rt_mag : rs_mag;
      acc    <= {WIDTH'(0), (bus.op[0] ? rs_mag : rt_mag)};
    end else if (state == CALC) begin
      acc <= acc_step;
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_mult_div_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  exp_t        sb_q[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  mult_div_unit_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .ITER(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, q, r;
    logic [63:0] p;
    bit          uns;
`ifdef MULTDIV_UNSIGNED_EN
    uns = op[1];
`else
    uns = 1'b0;
`endif
    e.dz  = 1'b0;
    e.cyc = 0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!op[0]) begin
      if (uns) p = {32'h0, a} * {32'h0, b};
      else     p = sa * sb;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 32'h0) begin
      e.dz = 1'b1;
      e.hi = model_hi;
      e.lo = model_lo;
    end else if (uns) begin
      e.lo = a / b;
      e.hi = a % b;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e.lo = q[31:0];
      e.hi = r[31:0];
    end
    return e;
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] edges [5];
    edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    if ($urandom_range(3) == 0) return edges[$urandom_range(4)];
    return $urandom;
  endfunction

  // Monitor: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && bus.done) begin
      if (sb_q.size() == 0) check("unexpected_done", 1, 0);
      else begin
        e = sb_q.pop_front();
        check("hi_out", bus.hi_out, e.hi);
        check("lo_out", bus.lo_out, e.lo);
        check("div_zero", bus.div_zero, e.dz);
        check("done_cycle", cyc, e.cyc);
      end
    end else if (reset_n && bus.div_zero) begin
      check("div_zero_without_done", 1, 0);
    end
  end

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int stray_at, input bit start_at_done, input int abort_at);
    exp_t e;
    int   lat;
    bit   busy_bad;
    e   = model(op, a, b);
    lat = e.dz ? 1 : 34;
    busy_bad = 1'b0;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    e.cyc      = cyc + lat;
    sb_q.push_back(e);
    for (int k = 1; k <= lat + 2; k++) begin
      @(negedge clk);
      if (k == abort_at) begin
        reset_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_hi", bus.hi_out, 0);
        check("abort_lo", bus.lo_out, 0);
        check("abort_done", bus.done, 0);
        sb_q.delete();
        model_hi = '0;
        model_lo = '0;
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_abort_idle", {bus.busy, bus.done}, 0);
        return;
      end
      if (bus.busy !== ((!e.dz && k <= 33) ? 1'b1 : 1'b0)) busy_bad = 1'b1;
      bus.start  = ((k == stray_at) && (k < lat)) || (start_at_done && (k == lat));
      bus.op     = 2'($urandom);
      bus.rs_val = $urandom;
      bus.rt_val = $urandom;
    end
    check("busy_profile", busy_bad, 0);
    check("result_pending", sb_q.size(), 0);
    sb_q.delete();
    if (!e.dz) begin
      model_hi = e.hi;
      model_lo = e.lo;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset_n    = 1'b0;
    bus.start  = 1'b0;
    bus.op     = 2'b00;
    bus.rs_val = '0;
    bus.rt_val = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_div_zero", bus.div_zero, 0);
    check("reset_hi", bus.hi_out, 0);
    check("reset_lo", bus.lo_out, 0);
    reset_n = 1'b1;

    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 0, 1'b0, 0);
    check("mult7x-3_hi", bus.hi_out, 32'hFFFF_FFFF);
    check("mult7x-3_lo", bus.lo_out, 32'hFFFF_FFEB);
    run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 0, 1'b0, 0);
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, 0);
    check("ovf_lo", bus.lo_out, 32'h8000_0000);
    run_op(2'b01, 32'h0000_2211, 32'h0000_0100, 0, 1'b0, 0);
    run_op(2'b01, 32'd5, 32'd0, 0, 1'b0, 0);
    check("dz_hold_hi", bus.hi_out, 32'h11);
    check("dz_hold_lo", bus.lo_out, 32'h22);
    run_op(2'b00, 32'h0001_0000, 32'h0001_0000, 10, 1'b1, 0);
    run_op(2'b01, 32'd1000, 32'd7, 0, 1'b0, 15);
    run_op(2'b00, 32'd2, 32'd3, 0, 1'b0, 0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'd2, 0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom), pick(), pick(),
             ($urandom_range(3) == 0) ? int'($urandom_range(30, 2)) : 0,
             1'($urandom), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
